// File: rtl/unified_mem_arbiter.sv
// Arbiter sharing one fixed-latency unified memory between IF and MEM.
// Serialises fetch/data requests and returns data with a done pulse.
`timescale 1ns/1ps
module unified_mem_arbiter #(
  parameter int LAT        = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [63:0] i_adr,
  input  logic        i_flush,
  output logic        i_done,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [63:0] d_adr,
  input  logic [63:0] d_wdata,
  output logic        d_done,
  output logic [63:0] d_rdata,
  output logic        stall_if,
  output logic        stall_mem,
  output logic        m_en,
  output logic        m_we,
  output logic [63:0] m_adr,
  output logic [63:0] m_wdata,
  input  logic [63:0] m_rdata
);

  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic            r_owner_i;
  logic [63:2]     r_adr;
  logic            r_we;
  logic [63:0]     r_wdata;
  logic [63:0]     r_rdata;
  logic [CW-1:0]   r_lat;
  logic [SW-1:0]   r_starve;
  logic            r_flushed;
  logic            w_any_req;
  logic            w_starved;
  logic            w_grant_i;
  logic            w_resp;
  logic            w_unused_lo;

  // Byte-offset bits below the access size are ignored by design.
  assign w_unused_lo = ^{i_adr[1:0], d_adr[1:0]};

  assign w_any_req = i_req | d_req;
  assign w_starved = (r_starve == SW'(STARVE_MAX));
  assign w_grant_i = i_req & (~d_req | w_starved);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic: one access per pass IDLE->ISSUE->WAIT->RESP.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:  if (w_any_req) w_next = ISSUE;
      ISSUE: w_next = WAIT;
      WAIT:  if (r_lat == '0) w_next = RESP;
      RESP:  w_next = IDLE;
    endcase
  end

  // Grant latch, starvation counter, latency counter and response capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner_i <= 1'b0;
      r_adr     <= '0;
      r_we      <= 1'b0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_lat     <= '0;
      r_starve  <= '0;
      r_flushed <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_owner_i <= w_grant_i;
            r_flushed <= 1'b0;
            if (w_grant_i) begin
              r_adr    <= i_adr[63:2];
              r_we     <= 1'b0;
              r_wdata  <= '0;
              r_starve <= '0;
            end else begin
              r_adr   <= d_adr[63:2];
              r_we    <= d_we;
              r_wdata <= d_wdata;
              if (!i_req)         r_starve <= '0;
              else if (!w_starved) r_starve <= r_starve + SW'(1);
            end
          end
        end
        ISSUE: begin
          r_lat <= CW'(LAT - 1);
          if (r_owner_i && i_flush) r_flushed <= 1'b1;
        end
        WAIT: begin
          if (r_owner_i && i_flush) r_flushed <= 1'b1;
          if (r_lat != '0) r_lat <= r_lat - CW'(1);
          else             r_rdata <= r_we ? 64'h0 : m_rdata;
        end
        RESP: begin
        end
      endcase
    end
  end

  assign w_resp = (r_state == RESP);

  // Output decode: memory strobes, done pulses, read data and stalls.
  always_comb begin
    m_en      = (r_state == ISSUE);
    m_we      = (r_state == ISSUE) & r_we;
    m_adr     = {r_adr[63:3], 3'b000};
    m_wdata   = r_wdata;
    i_done    = w_resp & r_owner_i & i_req & ~r_flushed & ~i_flush;
    d_done    = w_resp & ~r_owner_i & d_req;
    i_rdata   = '0;
    if (i_done) i_rdata = r_adr[2] ? r_rdata[63:32] : r_rdata[31:0];
    d_rdata   = d_done ? r_rdata : 64'h0;
    stall_if  = i_req & ~i_done;
    stall_mem = d_req & ~d_done;
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: directed requests, expected strobes and
// responses queued with their cycle numbers, checked by a monitor.
`timescale 1ns/1ps
module tb_unified_mem_arbiter;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_req = 1'b0;
  logic [63:0] i_adr = '0;
  logic        i_flush = 1'b0;
  logic        i_done;
  logic [31:0] i_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [63:0] d_adr = '0;
  logic [63:0] d_wdata = '0;
  logic        d_done;
  logic [63:0] d_rdata;
  logic        stall_if;
  logic        stall_mem;
  logic        m_en;
  logic        m_we;
  logic [63:0] m_adr;
  logic [63:0] m_wdata;
  logic [63:0] m_rdata;

  unified_mem_arbiter #(.LAT(LAT), .STARVE_MAX(3)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_adr(i_adr), .i_flush(i_flush),
    .i_done(i_done), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_adr(d_adr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata),
    .stall_if(stall_if), .stall_mem(stall_mem),
    .m_en(m_en), .m_we(m_we), .m_adr(m_adr), .m_wdata(m_wdata),
    .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Memory model: read data appears LAT cycles after the strobe cycle.
  logic [63:0] mem [0:511];
  logic [63:0] pipe [LAT];
  logic [63:0] rd;
  assign m_rdata = pipe[LAT-1];

  always @(posedge clk) begin
    rd = 64'h0BAD_0BAD_0BAD_0BAD;
    if (m_en) begin
      rd = mem[m_adr[11:3]];
      if (m_we) mem[m_adr[11:3]] = m_wdata;
    end
    pipe[0] <= rd;
    for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
  end

  typedef struct {
    bit          we;
    logic [63:0] adr;
    logic [63:0] wdata;
    int          cyc;
  } mreq_t;

  typedef struct {
    bit          is_i;
    logic [63:0] data;
    int          cyc;
  } resp_t;

  mreq_t mq[$];
  resp_t rq[$];
  mreq_t me;
  resp_t re;
  int n_vec = 0;
  int n_err = 0;

  task automatic push_m(input bit we, input logic [63:0] adr,
                        input logic [63:0] wd, input int c);
    mreq_t e;
    e.we = we; e.adr = adr; e.wdata = wd; e.cyc = c;
    mq.push_back(e);
  endtask

  task automatic push_r(input bit is_i, input logic [63:0] data,
                        input int c);
    resp_t e;
    e.is_i = is_i; e.data = data; e.cyc = c;
    rq.push_back(e);
  endtask

  task automatic chk(input string name, input logic [63:0] got,
                     input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Monitor: every strobe and every done pulse must match the queue head.
  always @(negedge clk) begin
    if (!rst) begin
      if (m_en) begin
        n_vec++;
        if (mq.size() == 0) begin
          n_err++;
          $display("FAIL strobe: unexpected at cyc %0d adr %h", cyc, m_adr);
        end else begin
          me = mq.pop_front();
          if (m_we !== me.we || m_adr !== me.adr || cyc != me.cyc ||
              (me.we && m_wdata !== me.wdata)) begin
            n_err++;
            $display("FAIL strobe: got we=%0b adr=%h wd=%h cyc=%0d want we=%0b adr=%h wd=%h cyc=%0d",
                     m_we, m_adr, m_wdata, cyc, me.we, me.adr, me.wdata, me.cyc);
          end
        end
      end
      if (i_done || d_done) begin
        n_vec++;
        if (rq.size() == 0) begin
          n_err++;
          $display("FAIL done: unexpected i_done=%0b d_done=%0b at cyc %0d",
                   i_done, d_done, cyc);
        end else begin
          re = rq.pop_front();
          if (i_done !== re.is_i || d_done !== !re.is_i || cyc != re.cyc ||
              (i_done ? {32'h0, i_rdata} : d_rdata) !== re.data) begin
            n_err++;
            $display("FAIL done: got i=%0b d=%0b data=%h/%h cyc=%0d want i=%0b data=%h cyc=%0d",
                     i_done, d_done, i_rdata, d_rdata, cyc, re.is_i, re.data, re.cyc);
          end
        end
      end
    end
  end

  task automatic wait_i(input int budget);
    bit seen = 0;
    for (int k = 0; k < budget && !seen; k++) begin
      @(negedge clk);
      seen = i_done;
    end
    if (!seen) begin
      n_vec++; n_err++;
      $display("FAIL timeout_i: got no i_done want i_done within %0d", budget);
    end
  endtask

  task automatic wait_d(input int budget);
    bit seen = 0;
    for (int k = 0; k < budget && !seen; k++) begin
      @(negedge clk);
      seen = d_done;
    end
    if (!seen) begin
      n_vec++; n_err++;
      $display("FAIL timeout_d: got no d_done want d_done within %0d", budget);
    end
  endtask

  int t0;

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 64'h0;
    for (int k = 0; k < LAT; k++) pipe[k] = 64'h0;
    mem[0]  = 64'hDEAD_BEEF_0BAD_F00D;
    mem[1]  = 64'h0123_4567_89AB_CDEF;
    mem[2]  = 64'h1111_2222_3333_4444;
    mem[3]  = 64'h5555_6666_7777_8888;
    mem[32] = 64'hFEDC_BA98_7654_3210;

    // Reset values; stall lines stay combinational.
    i_req = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outs", {m_en, m_we, i_done, d_done, stall_mem}, 64'h0);
    chk("rst_madr", m_adr, 64'h0);
    chk("rst_drdata", d_rdata, 64'h0);
    chk("rst_stall_if", {63'h0, stall_if}, 64'h1);
    i_req = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(posedge clk);

    // Reset asserted during ISSUE drops the strobe at once.
    #1 i_req = 1'b1; i_adr = 64'h8;
    @(posedge clk); #2;
    chk("issue_m_en", {63'h0, m_en}, 64'h1);
    #1 rst = 1'b1;
    #1 chk("rst_issue_m_en", {63'h0, m_en}, 64'h0);
    i_req = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    repeat (8) @(posedge clk);

    // Reset asserted during WAIT discards the response.
    #1 t0 = cyc; i_req = 1'b1; i_adr = 64'h8;
    push_m(0, 64'h8, 64'h0, t0 + 1);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    #1 chk("rst_wait_outs", {m_en, i_done, d_done}, 64'h0);
    i_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (8) @(posedge clk);

    // Fetch only; upper word of doubleword 0.
    #1 t0 = cyc; i_req = 1'b1; i_adr = 64'h4;
    push_m(0, 64'h0, 64'h0, t0 + 1);
    push_r(1, 64'hDEAD_BEEF, t0 + 4);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("stall_if_hi", {63'h0, stall_if}, 64'h1);
    end
    @(negedge clk);
    chk("stall_if_lo", {63'h0, stall_if}, 64'h0);
    @(posedge clk); #1 i_req = 1'b0;
    repeat (3) @(posedge clk);

    // Simultaneous requests: data first, then fetch.
    #1 t0 = cyc;
    i_req = 1'b1; i_adr = 64'h8;
    d_req = 1'b1; d_we = 1'b0; d_adr = 64'h100;
    push_m(0, 64'h100, 64'h0, t0 + 1);
    push_r(0, 64'hFEDC_BA98_7654_3210, t0 + 4);
    push_m(0, 64'h8, 64'h0, t0 + 6);
    push_r(1, 64'h89AB_CDEF, t0 + 9);
    fork
      begin wait_i(20); @(posedge clk); #1 i_req = 1'b0; end
      begin wait_d(20); @(posedge clk); #1 d_req = 1'b0; end
    join
    repeat (3) @(posedge clk);

    // Starvation limit: D, D, D, I, D.
    #1 t0 = cyc;
    i_req = 1'b1; i_adr = 64'h1C;
    d_req = 1'b1; d_adr = 64'h10;
    for (int k = 0; k < 3; k++) begin
      push_m(0, 64'h10, 64'h0, t0 + 1 + 5 * k);
      push_r(0, 64'h1111_2222_3333_4444, t0 + 4 + 5 * k);
    end
    push_m(0, 64'h18, 64'h0, t0 + 16);
    push_r(1, 64'h5555_6666, t0 + 19);
    push_m(0, 64'h10, 64'h0, t0 + 21);
    push_r(0, 64'h1111_2222_3333_4444, t0 + 24);
    fork
      begin wait_i(40); @(posedge clk); #1 i_req = 1'b0; end
      begin repeat (4) wait_d(40); @(posedge clk); #1 d_req = 1'b0; end
    join
    repeat (3) @(posedge clk);

    // Store, then load it back with a flush pulse that must be ignored.
    #1 t0 = cyc;
    d_req = 1'b1; d_we = 1'b1; d_adr = 64'h40;
    d_wdata = 64'h1122_3344_5566_7788;
    push_m(1, 64'h40, 64'h1122_3344_5566_7788, t0 + 1);
    push_r(0, 64'h0, t0 + 4);
    wait_d(20);
    @(posedge clk); #1 d_req = 1'b0; d_we = 1'b0; d_wdata = '0;
    repeat (2) @(posedge clk);
    #1 t0 = cyc; d_req = 1'b1; d_adr = 64'h40;
    push_m(0, 64'h40, 64'h0, t0 + 1);
    push_r(0, 64'h1122_3344_5566_7788, t0 + 4);
    repeat (2) @(posedge clk);
    #1 i_flush = 1'b1;
    @(posedge clk); #1 i_flush = 1'b0;
    wait_d(20);
    @(posedge clk); #1 d_req = 1'b0;
    repeat (3) @(posedge clk);

    // Flush during WAIT: no i_done; refetch of a new address follows.
    #1 t0 = cyc; i_req = 1'b1; i_adr = 64'h8;
    push_m(0, 64'h8, 64'h0, t0 + 1);
    push_m(0, 64'h18, 64'h0, t0 + 6);
    push_r(1, 64'h5555_6666, t0 + 9);
    repeat (2) @(posedge clk);
    #1 i_flush = 1'b1;
    @(posedge clk); #1 i_flush = 1'b0; i_adr = 64'h1C;
    wait_i(20);
    @(posedge clk); #1 i_req = 1'b0;
    repeat (3) @(posedge clk);

    // Request withdrawn after grant: access runs, no done pulse.
    #1 t0 = cyc; d_req = 1'b1; d_adr = 64'h100;
    push_m(0, 64'h100, 64'h0, t0 + 1);
    @(posedge clk); #1 d_req = 1'b0;
    repeat (8) @(posedge clk);

    #1;
    chk("strobe_q_empty", 64'(mq.size()), 64'h0);
    chk("resp_q_empty", 64'(rq.size()), 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end want end by 200000");
    $fatal(1);
  end

endmodule
